// File: rtl/qu_common.sv
// Shared definitions for the front-end stage queue family.
// The QU_FEQ_STATS_EN build macro is consumed by fe_stage_queue, not by this package.
package qu_common;

  localparam int unsigned QU_FEQ_MAX_LANES     = 4;
  localparam int unsigned QU_FEQ_DEFAULT_DEPTH = 12;

  // Occupancy type for the default depth; instances re-derive widths from their own parameters.
  typedef logic [$clog2(QU_FEQ_DEFAULT_DEPTH + 1) - 1:0] feq_cnt_t;

  // Number of contiguous set bits starting at bit 0.
  function automatic int unsigned qu_prefix_ones(input logic [QU_FEQ_MAX_LANES-1:0] vec);
    int unsigned n;
    logic        run;
    n   = 0;
    run = 1'b1;
    for (int i = 0; i < QU_FEQ_MAX_LANES; i++) begin
      if (run && vec[i]) begin
        n = n + 1;
      end else begin
        run = 1'b0;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/fe_queue_lane_mux.sv
// Modulo-DEPTH lane index generator and storage selector for the stage queue.
// Used both for head-entry read selection and for tail write-index fan-out.
module fe_queue_lane_mux #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 12,
  parameter int unsigned LANES      = 2,
  localparam int unsigned PtrW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic [PtrW-1:0]                   base_i,
  input  logic [DEPTH-1:0][DATA_WIDTH-1:0]  mem_i,
  output logic [LANES-1:0][PtrW-1:0]        idx_o,
  output logic [LANES-1:0][DATA_WIDTH-1:0]  data_o
);

  int unsigned sum;

  // base < DEPTH and lane < DEPTH, so one conditional subtract is enough.
  always_comb begin
    idx_o  = '0;
    data_o = '0;
    sum    = 0;
    for (int unsigned i = 0; i < LANES; i++) begin
      sum = 32'(base_i) + i;
      if (sum >= DEPTH) begin
        sum = sum - DEPTH;
      end
      idx_o[i]  = PtrW'(sum);
      data_o[i] = mem_i[PtrW'(sum)];
    end
  end

endmodule

// File: rtl/fe_stage_queue.sv
// Multi-lane decoupling queue between front-end stages with partial acceptance and flush.
// Define QU_FEQ_STATS_EN to build the high-water-mark and reject-count statistics.
module fe_stage_queue
  import qu_common::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 12,
  parameter int unsigned WR_LANES   = 2,
  parameter int unsigned RD_LANES   = 2,
  localparam int unsigned CntW      = $clog2(DEPTH + 1),
  localparam int unsigned WaW       = $clog2(WR_LANES + 1),
  localparam int unsigned TakeW     = $clog2(RD_LANES + 1),
  localparam int unsigned PtrW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           flush_i,
  input  logic [WR_LANES-1:0]            wr_valid_i,
  input  logic [WR_LANES*DATA_WIDTH-1:0] wr_data_i,
  output logic [WaW-1:0]                 wr_accept_cnt_o,
  output logic [RD_LANES-1:0]            rd_valid_o,
  output logic [RD_LANES*DATA_WIDTH-1:0] rd_data_o,
  input  logic [TakeW-1:0]               rd_take_i,
  output logic [CntW-1:0]                count_o,
  output logic                           empty_o,
  output logic                           full_o,
  output logic [CntW-1:0]                stat_hwm_o,
  output logic [31:0]                    stat_reject_cnt_o
);

  logic [DEPTH-1:0][DATA_WIDTH-1:0]    mem_q, mem_d;
  logic [PtrW-1:0]                     head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]                     count_q, count_d;

  logic [WR_LANES-1:0][DATA_WIDTH-1:0] wr_lanes;
  logic [QU_FEQ_MAX_LANES-1:0]         wr_valid_ext;
  logic [WR_LANES-1:0][PtrW-1:0]       wr_idx;
  logic [WR_LANES-1:0][DATA_WIDTH-1:0] unused_wr_data;
  logic [RD_LANES-1:0][PtrW-1:0]       unused_rd_idx;
  logic [RD_LANES-1:0][DATA_WIDTH-1:0] rd_lanes;

  int unsigned prefix_n, free_n, accept_n, pop_n, head_sum, tail_sum;

  assign wr_lanes     = wr_data_i;
  assign wr_valid_ext = QU_FEQ_MAX_LANES'(wr_valid_i);

  fe_queue_lane_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .LANES      (WR_LANES)
  ) u_wr_mux (
    .base_i (tail_q),
    .mem_i  (mem_q),
    .idx_o  (wr_idx),
    .data_o (unused_wr_data)
  );

  fe_queue_lane_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .LANES      (RD_LANES)
  ) u_rd_mux (
    .base_i (head_q),
    .mem_i  (mem_q),
    .idx_o  (unused_rd_idx),
    .data_o (rd_lanes)
  );

  // Free space comes from the start-of-cycle count: a same-cycle pop never frees a slot.
  always_comb begin
    prefix_n = qu_prefix_ones(wr_valid_ext);
    free_n   = DEPTH - 32'(count_q);
    accept_n = flush_i ? 0 : ((prefix_n < free_n) ? prefix_n : free_n);
    pop_n    = (32'(rd_take_i) < 32'(count_q)) ? 32'(rd_take_i) : 32'(count_q);
  end

  always_comb begin
    head_sum = 32'(head_q) + pop_n;
    if (head_sum >= DEPTH) begin
      head_sum = head_sum - DEPTH;
    end
    tail_sum = 32'(tail_q) + accept_n;
    if (tail_sum >= DEPTH) begin
      tail_sum = tail_sum - DEPTH;
    end
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = PtrW'(head_sum);
      tail_d  = PtrW'(tail_sum);
      count_d = CntW'(32'(count_q) + accept_n - pop_n);
    end
  end

  always_comb begin
    mem_d = mem_q;
    for (int unsigned i = 0; i < WR_LANES; i++) begin
      if (i < accept_n) begin
        mem_d[wr_idx[i]] = wr_lanes[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; validity is tracked entirely by count_q.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  always_comb begin
    rd_valid_o = '0;
    for (int unsigned i = 0; i < RD_LANES; i++) begin
      rd_valid_o[i] = (i < 32'(count_q));
    end
  end

  assign rd_data_o       = rd_lanes;
  assign wr_accept_cnt_o = WaW'(accept_n);
  assign count_o         = count_q;
  assign empty_o         = (count_q == '0);
  assign full_o          = (count_q == CntW'(DEPTH));

`ifdef QU_FEQ_STATS_EN
  logic [CntW-1:0] hwm_q, hwm_d;
  logic [31:0]     rej_q, rej_d;
  logic [32:0]     rej_sum;

  // Rejects are all valid lanes not accepted, including those above the first gap.
  always_comb begin
    hwm_d   = (count_d > hwm_q) ? count_d : hwm_q;
    rej_sum = {1'b0, rej_q} + 33'($countones(wr_valid_i)) - 33'(accept_n);
    rej_d   = rej_sum[32] ? 32'hFFFF_FFFF : rej_sum[31:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hwm_q <= '0;
      rej_q <= '0;
    end else begin
      hwm_q <= hwm_d;
      rej_q <= rej_d;
    end
  end

  assign stat_hwm_o        = hwm_q;
  assign stat_reject_cnt_o = rej_q;
`else
  assign stat_hwm_o        = '0;
  assign stat_reject_cnt_o = '0;
`endif

`ifndef SYNTHESIS
  count_le_depth_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_q <= CntW'(DEPTH));
`endif

endmodule

// File: tb/tb_fe_stage_queue.sv
// Scoreboard bench for fe_stage_queue: directed test-plan sequences followed by random traffic.
module tb_fe_stage_queue;

  localparam int unsigned DW    = 64;
  localparam int unsigned DEPTH = 12;
  localparam int unsigned WRL   = 2;
  localparam int unsigned RDL   = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               flush = 1'b0;
  logic [WRL-1:0]     wr_valid = '0;
  logic [WRL*DW-1:0]  wr_data = '0;
  logic [1:0]         wr_accept_cnt;
  logic [RDL-1:0]     rd_valid;
  logic [RDL*DW-1:0]  rd_data;
  logic [1:0]         rd_take = '0;
  logic [3:0]         count;
  logic               empty;
  logic               full;
  logic [3:0]         stat_hwm;
  logic [31:0]        stat_rej;

  always #5 clk = ~clk;

  fe_stage_queue #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .WR_LANES   (WRL),
    .RD_LANES   (RDL)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .flush_i           (flush),
    .wr_valid_i        (wr_valid),
    .wr_data_i         (wr_data),
    .wr_accept_cnt_o   (wr_accept_cnt),
    .rd_valid_o        (rd_valid),
    .rd_data_o         (rd_data),
    .rd_take_i         (rd_take),
    .count_o           (count),
    .empty_o           (empty),
    .full_o            (full),
    .stat_hwm_o        (stat_hwm),
    .stat_reject_cnt_o (stat_rej)
  );

  typedef struct {
    int              acc;
    int              cnt;
    int              take;
    bit              fl;
    int              hwm;
    longint unsigned rej;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] sb_data[$];
  int          checks = 0;
  int          errors = 0;

  // Reference model state: occupancy and statistics as the queue rules define them.
  int              mcount = 0;
  int              mhwm   = 0;
  longint unsigned mrej   = 0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic longint unsigned stat_exp(input longint unsigned v);
`ifdef QU_FEQ_STATS_EN
    return v;
`else
    return (v == 0) ? 0 : 0;
`endif
  endfunction

  task automatic step(input logic [1:0] v, input logic [63:0] d0, input logic [63:0] d1,
                      input int take, input bit fl);
    int   p, above, acc, e;
    exp_t r;
    logic [63:0] d[2];
    @(negedge clk);
    wr_valid = v;
    wr_data  = {d1, d0};
    rd_take  = 2'(take);
    flush    = fl;
    d[0] = d0;
    d[1] = d1;
    p = 0;
    while (p < WRL && v[p]) p++;
    above = 0;
    for (int i = p; i < WRL; i++) above += v[i] ? 1 : 0;
    acc = fl ? 0 : ((p < DEPTH - mcount) ? p : DEPTH - mcount);
    e   = fl ? 0 : ((take < mcount) ? take : mcount);
    r.acc  = acc;
    r.cnt  = mcount;
    r.take = e;
    r.fl   = fl;
    r.hwm  = mhwm;
    r.rej  = mrej;
    exp_q.push_back(r);
    for (int i = 0; i < acc; i++) sb_data.push_back(d[i]);
    mcount = fl ? 0 : mcount + acc - e;
    if (mcount > mhwm) mhwm = mcount;
    mrej = mrej + longint'(p - acc + above);
    if (mrej > 64'hFFFF_FFFF) mrej = 64'hFFFF_FFFF;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n    = 1'b0;
    wr_valid = '0;
    flush    = 1'b0;
    rd_take  = '0;
    mcount   = 0;
    mhwm     = 0;
    mrej     = 0;
    sb_data.delete();
    #1;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_accept", wr_accept_cnt, 0);
    check("rst_hwm", stat_hwm, 0);
    check("rst_reject", stat_rej, 0);
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: one expectation record per cycle, read data checked against the scoreboard queue.
  initial begin
    exp_t r;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        r = exp_q.pop_front();
        check("accept", wr_accept_cnt, r.acc);
        check("count", count, r.cnt);
        check("empty", empty, r.cnt == 0);
        check("full", full, r.cnt == DEPTH);
        for (int i = 0; i < RDL; i++) begin
          check("rd_valid", rd_valid[i], i < r.cnt);
          if (i < r.cnt) begin
            if (i < sb_data.size()) check("rd_data", rd_data[i*DW +: DW], sb_data[i]);
            else check("sb_underrun", 1, 0);
          end
        end
        for (int i = 0; i < r.take; i++) if (sb_data.size() != 0) void'(sb_data.pop_front());
        if (r.fl) sb_data.delete();
        check("stat_hwm", stat_hwm, stat_exp(r.hwm));
        check("stat_reject", stat_rej, stat_exp(r.rej));
      end
    end
  end

  initial begin
    do_reset(3);
    step(2'b00, 0, 0, 0, 0);
    step(2'b00, 0, 0, 0, 0);

    // Fill to full with A0..AB, then a rejected write alongside a pop, then wrap.
    for (int k = 0; k < 6; k++) step(2'b11, 64'hA0 + 2 * k, 64'hA1 + 2 * k, 0, 0);
    step(2'b11, 64'hB0, 64'hB1, 2, 0);
    step(2'b11, 64'hC0, 64'hC1, 0, 0);
    for (int k = 0; k < 7; k++) step(2'b00, 0, 0, 2, 0);

    // Non-contiguous valid on an empty queue.
    do_reset(1);
    step(2'b10, 64'hD0, 64'hD1, 0, 0);
    step(2'b00, 0, 0, 0, 0);

    // Partial space: count 11, two lanes offered.
    for (int k = 0; k < 5; k++) step(2'b11, 64'h100 + k, 64'h200 + k, 0, 0);
    step(2'b01, 64'h300, 64'h0, 0, 0);
    step(2'b11, 64'h400, 64'h401, 0, 0);
    step(2'b00, 0, 0, 0, 0);

    // Flush with traffic at count 5.
    do_reset(1);
    step(2'b11, 64'h500, 64'h501, 0, 0);
    step(2'b11, 64'h502, 64'h503, 0, 0);
    step(2'b01, 64'h504, 64'h0, 0, 0);
    step(2'b11, 64'h505, 64'h506, 2, 1);
    step(2'b00, 0, 0, 0, 0);
    step(2'b11, 64'h600, 64'h601, 0, 0);
    step(2'b00, 0, 0, 2, 0);

    // Over-take clamp.
    step(2'b01, 64'h700, 64'h0, 0, 0);
    step(2'b00, 0, 0, 2, 0);
    step(2'b00, 0, 0, 2, 0);

    // Random traffic with a mid-run reset.
    for (int n = 0; n < 800; n++) begin
      if (n == 400) do_reset(2);
      step(2'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom},
           (n % 200 < 100) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 2)),
           $urandom_range(0, 29) == 0);
    end
    step(2'b00, 0, 0, 0, 0);
    @(negedge clk);
    #4;
    if (exp_q.size() != 0) check("pending_records", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
